// File: rtl/baccarat_datapath_pkg.sv
// Shared definitions for the Baccarat card datapath: card codes,
// active-low seven-segment patterns {g,f,e,d,c,b,a}, and card point value.
package baccarat_datapath_pkg;

  // Card codes
  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_ACE  = 4'd1;
  localparam logic [3:0] CARD_10   = 4'd10;
  localparam logic [3:0] CARD_J    = 4'd11;
  localparam logic [3:0] CARD_Q    = 4'd12;
  localparam logic [3:0] CARD_K    = 4'd13;

  // Seven-segment patterns, active low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ACE   = 7'b0001000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_10    = 7'b1000000;
  localparam logic [6:0] SEG_J     = 7'b1100001;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_K     = 7'b0001001;

  // Point value of a card: Ace..9 count face value, everything else counts 0.
  function automatic logic [3:0] card_value(input logic [3:0] card);
    logic [3:0] value;
    if ((card >= CARD_ACE) && (card <= 4'd9)) begin
      value = card;
    end else begin
      value = 4'd0;
    end
    return value;
  endfunction

endpackage

// File: rtl/baccarat_datapath_card7seg.sv
// card7seg: decodes a 4-bit card code into an active-low seven-segment
// pattern. No-card and illegal codes (0, 14, 15) blank the display.
module card7seg
  import baccarat_datapath_pkg::*;
(
  input  logic [3:0] card,
  output logic [6:0] seg
);

  // Card code to segment pattern lookup
  always_comb begin
    seg = SEG_BLANK;
    case (card)
      CARD_ACE: seg = SEG_ACE;
      4'd2:     seg = SEG_2;
      4'd3:     seg = SEG_3;
      4'd4:     seg = SEG_4;
      4'd5:     seg = SEG_5;
      4'd6:     seg = SEG_6;
      4'd7:     seg = SEG_7;
      4'd8:     seg = SEG_8;
      4'd9:     seg = SEG_9;
      CARD_10:  seg = SEG_10;
      CARD_J:   seg = SEG_J;
      CARD_Q:   seg = SEG_Q;
      CARD_K:   seg = SEG_K;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/baccarat_datapath.sv
// baccarat_datapath: free-running deal counter, six card registers loaded on
// controller strobes, player/banker scores, and six HEX displays.
// Optional feature macro: DATAPATH_DEAL_OVERRIDE_EN adds deal_ovr_valid and
// deal_ovr so a test harness can force the dealt card value.
module baccarat_datapath
  import baccarat_datapath_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
`ifdef DATAPATH_DEAL_OVERRIDE_EN
  input  logic       deal_ovr_valid,
  input  logic [3:0] deal_ovr,
`endif
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard3_out,
  output logic [3:0] pscore_out,
  output logic [3:0] dscore_out,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  logic [3:0] dealcard;
  logic [3:0] load_card;
  logic [3:0] pcard1, pcard2, pcard3;
  logic [3:0] dcard1, dcard2, dcard3;
  logic [4:0] psum, dsum;

`ifdef DATAPATH_DEAL_OVERRIDE_EN
  assign load_card = deal_ovr_valid ? deal_ovr : dealcard;
`else
  assign load_card = dealcard;
`endif

  // Deal counter cycles Ace..King continuously, never holding 0/14/15
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      dealcard <= CARD_ACE;
    end else if (dealcard == CARD_K) begin
      dealcard <= CARD_ACE;
    end else begin
      dealcard <= dealcard + 4'd1;
    end
  end

  // Card registers capture the dealt value while their strobe is high
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      pcard1 <= CARD_NONE;
      pcard2 <= CARD_NONE;
      pcard3 <= CARD_NONE;
      dcard1 <= CARD_NONE;
      dcard2 <= CARD_NONE;
      dcard3 <= CARD_NONE;
    end else begin
      if (load_pcard1) pcard1 <= load_card;
      if (load_pcard2) pcard2 <= load_card;
      if (load_pcard3) pcard3 <= load_card;
      if (load_dcard1) dcard1 <= load_card;
      if (load_dcard2) dcard2 <= load_card;
      if (load_dcard3) dcard3 <= load_card;
    end
  end

  // Hand sums; three values of at most 9 fit in 5 bits
  assign psum = {1'b0, card_value(pcard1)} + {1'b0, card_value(pcard2)}
              + {1'b0, card_value(pcard3)};
  assign dsum = {1'b0, card_value(dcard1)} + {1'b0, card_value(dcard2)}
              + {1'b0, card_value(dcard3)};

  // Scores are the hand sums mod 10 (sum is at most 27)
  always_comb begin
    pscore_out = 4'd0;
    dscore_out = 4'd0;
    if (psum >= 5'd20) begin
      pscore_out = 4'(psum - 5'd20);
    end else if (psum >= 5'd10) begin
      pscore_out = 4'(psum - 5'd10);
    end else begin
      pscore_out = psum[3:0];
    end
    if (dsum >= 5'd20) begin
      dscore_out = 4'(dsum - 5'd20);
    end else if (dsum >= 5'd10) begin
      dscore_out = 4'(dsum - 5'd10);
    end else begin
      dscore_out = dsum[3:0];
    end
  end

  assign pcard3_out = pcard3;

  card7seg u_hex0 (.card(pcard1), .seg(HEX0));
  card7seg u_hex1 (.card(pcard2), .seg(HEX1));
  card7seg u_hex2 (.card(pcard3), .seg(HEX2));
  card7seg u_hex3 (.card(dcard1), .seg(HEX3));
  card7seg u_hex4 (.card(dcard2), .seg(HEX4));
  card7seg u_hex5 (.card(dcard3), .seg(HEX5));

endmodule

// File: tb/tb_baccarat_datapath.sv
// Self-checking bench for baccarat_datapath. A behavioural model tracks the
// six cards and the deal position; scores and displays are derived from the
// card table with plain arithmetic and a pattern lookup.
module tb_baccarat_datapath;

  logic       slow_clock = 1'b0;
  logic       resetb;
  logic [5:0] ld;          // {dcard3,dcard2,dcard1,pcard3,pcard2,pcard1}
  logic       ovr_valid;
  logic [3:0] ovr;
  logic [3:0] pcard3_out, pscore_out, dscore_out;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic [3:0] cards [6];
  int         deal;

  always #5 slow_clock = ~slow_clock;

  baccarat_datapath dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
`ifdef DATAPATH_DEAL_OVERRIDE_EN
    .deal_ovr_valid (ovr_valid),
    .deal_ovr       (ovr),
`endif
    .load_pcard1 (ld[0]),
    .load_pcard2 (ld[1]),
    .load_pcard3 (ld[2]),
    .load_dcard1 (ld[3]),
    .load_dcard2 (ld[4]),
    .load_dcard3 (ld[5]),
    .pcard3_out  (pcard3_out),
    .pscore_out  (pscore_out),
    .dscore_out  (dscore_out),
    .HEX0 (HEX0), .HEX1 (HEX1), .HEX2 (HEX2),
    .HEX3 (HEX3), .HEX4 (HEX4), .HEX5 (HEX5)
  );

  function automatic int pts(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? int'(c) : 0;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd1:  return 7'b0001000;
      4'd2:  return 7'b0100100;
      4'd3:  return 7'b0110000;
      4'd4:  return 7'b0011001;
      4'd5:  return 7'b0010010;
      4'd6:  return 7'b0000010;
      4'd7:  return 7'b1111000;
      4'd8:  return 7'b0000000;
      4'd9:  return 7'b0010000;
      4'd10: return 7'b1000000;
      4'd11: return 7'b1100001;
      4'd12: return 7'b0011000;
      4'd13: return 7'b0001001;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [53:0] exp_vec();
    int ps, ds;
    ps = (pts(cards[0]) + pts(cards[1]) + pts(cards[2])) % 10;
    ds = (pts(cards[3]) + pts(cards[4]) + pts(cards[5])) % 10;
    return {seg_of(cards[5]), seg_of(cards[4]), seg_of(cards[3]),
            seg_of(cards[2]), seg_of(cards[1]), seg_of(cards[0]),
            4'(ps), 4'(ds), cards[2]};
  endfunction

  function automatic logic [53:0] dut_vec();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, pscore_out, dscore_out, pcard3_out};
  endfunction

  // One rising edge; the model applies the same edge, then settles 1 time unit.
  task automatic tick();
    @(posedge slow_clock);
    if (resetb) begin
      for (int i = 0; i < 6; i++)
        if (ld[i]) cards[i] = ovr_valid ? ovr : 4'(deal);
      deal = (deal == 13) ? 1 : deal + 1;
    end
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) cards[i] = 4'd0;
    deal = 1;
  endtask

  // Load the registers in mask with card value val (waiting for the counter
  // to reach it when the override port is not built in).
  task automatic deal_to(input logic [5:0] mask, input int val);
`ifdef DATAPATH_DEAL_OVERRIDE_EN
    ovr_valid = 1'b1;
    ovr = 4'(val);
    ld = mask;
    tick();
    ld = 6'd0;
    ovr_valid = 1'b0;
`else
    int n = 0;
    ld = 6'd0;
    while (deal != val && n < 16) begin
      tick();
      n++;
    end
    if (deal != val) begin
      miscompares++;
      $display("FAIL deal_to_timeout: counter position %0d, required %0d", deal, val);
    end
    ld = mask;
    tick();
    ld = 6'd0;
`endif
  endtask

  task automatic test_reset();
    resetb = 1'b0; ld = 6'd0; ovr_valid = 1'b0; ovr = 4'd0;
    model_reset();
    #2;
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), exp_vec());
    end
    // Strobes held during reset must be ignored
    ld = 6'h3f;
    tick();
    tick();
    vectors++;
    if ({HEX0, HEX5, pscore_out, dscore_out, pcard3_out} !== {7'h7f, 7'h7f, 12'h000}) begin
      miscompares++;
      $display("FAIL reset_strobe_ignored: got %h want %h",
               {HEX0, HEX5, pscore_out, dscore_out, pcard3_out}, {7'h7f, 7'h7f, 12'h000});
    end
    ld = 6'd0;
  endtask

  task automatic test_deal_sequence();
    resetb = 1'b1;            // released mid-cycle; next edge is the first deal
    ld = 6'b000100;
    for (int i = 0; i < 14; i++) begin
      tick();
      vectors++;
      if (pcard3_out !== 4'((i % 13) + 1)) begin
        miscompares++;
        $display("FAIL deal_seq[%0d]: got %0d want %0d", i, pcard3_out, (i % 13) + 1);
      end
    end
    ld = 6'd0;
  endtask

  task automatic test_player_hand();
    deal_to(6'b000001, 10);
    deal_to(6'b000010, 5);
    deal_to(6'b000100, 12);
    vectors++;
    if ({HEX0, HEX1, HEX2, pscore_out, pcard3_out} !==
        {7'b1000000, 7'b0010010, 7'b0011000, 4'd5, 4'd12}) begin
      miscompares++;
      $display("FAIL player_hand: got %h want %h", {HEX0, HEX1, HEX2, pscore_out, pcard3_out},
               {7'b1000000, 7'b0010010, 7'b0011000, 4'd5, 4'd12});
    end
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL player_hand_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_banker_hand();
    deal_to(6'b001000, 1);
    deal_to(6'b010000, 6);
    deal_to(6'b100000, 3);
    vectors++;
    if ({dscore_out, HEX3} !== {4'd0, 7'b0001000}) begin
      miscompares++;
      $display("FAIL banker_hand: got %h want %h", {dscore_out, HEX3}, {4'd0, 7'b0001000});
    end
  endtask

  task automatic test_multi_load();
`ifdef DATAPATH_DEAL_OVERRIDE_EN
    int v = 15;
`else
    int v = 13;
`endif
    deal_to(6'b000011, v);
    vectors++;
    if ({HEX0, HEX1, HEX2, pscore_out} !==
        {seg_of(4'(v)), seg_of(4'(v)), 7'b0011000, 4'(pts(cards[2]))}) begin
      miscompares++;
      $display("FAIL multi_load: got %h want %h", {HEX0, HEX1, HEX2, pscore_out},
               {seg_of(4'(v)), seg_of(4'(v)), 7'b0011000, 4'(pts(cards[2]))});
    end
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL multi_load_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_nines();
    deal_to(6'b000001, 9);
    deal_to(6'b000010, 9);
    deal_to(6'b000100, 9);
    vectors++;
    if (pscore_out !== 4'd7) begin
      miscompares++;
      $display("FAIL nines_score: got %0d want 7", pscore_out);
    end
  endtask

  task automatic test_async_reset();
    deal_to(6'b111000, 8);
    @(posedge slow_clock);
    if (resetb) deal = (deal == 13) ? 1 : deal + 1;
    #3;
    resetb = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", dut_vec(), exp_vec());
    end
    #2;
    resetb = 1'b1;
    // First edge after release deals an Ace
    ld = 6'b000100;
    tick();
    ld = 6'd0;
    vectors++;
    if (pcard3_out !== 4'd1) begin
      miscompares++;
      $display("FAIL post_reset_first_deal: got %0d want 1", pcard3_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      ld = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
`ifdef DATAPATH_DEAL_OVERRIDE_EN
      ovr_valid = 1'($urandom);
      ovr = 4'($urandom);
`endif
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    ld = 6'd0;
    ovr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_deal_sequence();
    test_player_hand();
    test_banker_hand();
    test_multi_load();
    test_nines();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
